i2s_mic_rx: RTL
===============

I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 SHALL have parameter CLKDIV, default 8: clk cycles per BCLK half-period (48 MHz clk gives 3 MHz BCLK); legal range 2..255.
REQ-002 SHALL have parameter WARMUP_FRAMES, default 4: number of complete frames discarded after each start.
REQ-003 SHALL have port clk, input, 1: single system clock; every register in the block is clocked by it.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: capture enable; when low the I2S clocks stop.
REQ-006 SHALL have port i2s_sd, input, 1: microphone serial data, 24-bit two's complement, MSB first.
REQ-007 SHALL have port i2s_bclk, output, 1: I2S bit clock, registered.
REQ-008 SHALL have port i2s_lrclk, output, 1: I2S word select, registered; low selects the left slot.
REQ-009 SHALL have port pcm_out, output, 16: latest left-channel sample.
REQ-010 SHALL have port audio_valid, output, 1: an unconsumed sample is present; drives the downstream SPI stage.
REQ-011 SHALL have port sample_ack, input, 1: one-clk pulse from the consumer marking pcm_out as taken.
REQ-012 SHALL have port overrun, output, 1: sticky flag, set when a sample is overwritten before being acknowledged.

Function
REQ-013 SHALL run a divider counting 0..CLKDIV-1 while en=1 and toggle i2s_bclk at the terminal count.
REQ-014 SHALL generate internal one-clk strobes: rise on the 0->1 toggle of i2s_bclk and fall on the 1->0 toggle.
REQ-015 SHALL use a 6-bit bit_cnt that increments on each fall strobe and wraps from 63 to 0, giving 64 BCLKs per frame.
REQ-016 SHALL register i2s_lrclk = bit_cnt[5]: slot 0..31 is left (lrclk low), slot 32..63 is right.
REQ-017 SHALL implement FSM states WARMUP, DELAY, SHIFT, HOLD.
- DELAY covers slot 0, the one-BCLK I2S delay bit.
- SHIFT covers slots 1..24.
- HOLD covers slots 25..63, including the whole right slot.
REQ-018 SHALL shift i2s_sd into a 24-bit register on each rise strobe while in SHIFT, MSB first.
REQ-019 SHALL, on the rise strobe at slot 24 with warm-up complete, load pcm_out = shift[23:8] (truncate, no rounding) and set audio_valid on the following clk edge (1 clk latency).
REQ-020 SHALL never sample or use right-slot data.
REQ-021 SHALL count completed frames (bit_cnt wrap 63->0) while in WARMUP and leave WARMUP after WARMUP_FRAMES wraps; no sample is produced during warm-up.
REQ-022 SHALL clear audio_valid on sample_ack; sample_ack while audio_valid=0 is ignored.
REQ-023 SHALL, when a new capture occurs while audio_valid=1 and sample_ack=0, overwrite pcm_out, keep audio_valid=1 and set overrun.
REQ-024 SHALL treat a new capture and sample_ack in the same clk as an accepted hand-off: audio_valid stays 1, pcm_out takes the new sample, overrun is unchanged.
REQ-025 SHALL, while en=0, do all of the following:
- hold i2s_bclk=0 and i2s_lrclk=0;
- clear the divider and bit_cnt;
- discard any partial frame;
- hold pcm_out, audio_valid and overrun at their current values.
REQ-026 SHALL, on an en 0->1 transition, re-enter WARMUP and start at slot 0.
REQ-027 SHALL clear overrun only by reset.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force:
- i2s_bclk=0, i2s_lrclk=0;
- pcm_out=16'h0000, audio_valid=0, overrun=0;
- divider=0, bit_cnt=0, shift register=0;
- warm-up count=0 and FSM=WARMUP.
REQ-029 SHALL, after reset deassertion mid-frame, start a new frame at slot 0; no partial sample is ever produced.

Structure
REQ-030 SHALL take the following shared constants from karaoke_pkg: PCM_W=16, I2S_WORD_W=24, I2S_SLOT_W=32, and the FSM state enum.
REQ-031 SHALL place the divider and strobe logic in sub-module i2s_clkgen (ports: clk, reset_n, en, bclk, rise, fall); all remaining logic lives in i2s_mic_rx.

Verification (CLKDIV=2, WARMUP_FRAMES=1 unless stated otherwise)
REQ-032 SHALL cover reset: assert reset_n=0 mid-frame -> all outputs 0 immediately; after release, first rise strobe occurs 2 clks later and audio_valid stays 0 through frame 1.
REQ-033 SHALL cover basic capture: left word 24'hA5C37F in frame 2 -> pcm_out=16'hA5C3 and audio_valid=1 exactly 1 clk after the slot-24 rise strobe.
REQ-034 SHALL cover ack and overrun: pulse sample_ack -> audio_valid=0 next clk; then frames carrying 24'h123456 and 24'h89ABCD with no ack -> pcm_out=16'h89AB, overrun=1, and overrun stays 1 after a later ack.
REQ-035 SHALL cover channel selection: left=24'h000000, right=24'hFFFFFF -> pcm_out=16'h0000.
REQ-036 SHALL cover enable: drop en at slot 10 -> i2s_bclk=0 and no sample from that frame; raise en -> one warm-up frame is discarded before the next valid sample.
REQ-037 SHALL cover simultaneous events: sample_ack coincident with a capture of 24'h7FFF00 -> audio_valid stays 1, pcm_out=16'h7FFF, overrun=0.

Source files
------------

// File: rtl/karaoke_pkg.sv
// Shared audio-path constants and the I2S receiver state encoding.
package karaoke_pkg;

  localparam int unsigned PCM_W       = 16;
  localparam int unsigned I2S_WORD_W  = 24;
  localparam int unsigned I2S_SLOT_W  = 32;
  localparam int unsigned I2S_FRAME_W = 2 * I2S_SLOT_W;
  localparam int unsigned BIT_CNT_W   = $clog2(I2S_FRAME_W);

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_DELAY,
    ST_SHIFT,
    ST_HOLD
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock divider: toggles bclk every CLKDIV clk cycles and flags each
// edge with a one-clk strobe that is high during the first clk of the new level.
module i2s_clkgen #(
  parameter int unsigned CLKDIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned DIV_W = $clog2(CLKDIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tc_c;

  assign tc_c = (div_cnt == DIV_W'(CLKDIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tc_c) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
        rise    <= ~bclk;
        fall    <= bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: generates BCLK/LRCLK, captures the left 24-bit word,
// and presents its top 16 bits to a consumer with a valid/ack hand-off.
module i2s_mic_rx
  import karaoke_pkg::*;
#(
  parameter int unsigned CLKDIV        = 8,
  parameter int unsigned WARMUP_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             i2s_sd,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic [PCM_W-1:0] pcm_out,
  output logic             audio_valid,
  input  logic             sample_ack,
  output logic             overrun
);

  // WARMUP_FRAMES of 0 behaves as 1: the first frame after start is always dropped.
  localparam int unsigned WARM_LAST = (WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0;
  localparam int unsigned WARM_W    = (WARM_LAST > 0) ? $clog2(WARM_LAST + 1) : 1;
  localparam int unsigned LAST_SLOT = I2S_FRAME_W - 1;
  localparam int unsigned CAP_SLOT  = I2S_WORD_W;

  i2s_rx_state_e         state, state_nxt;
  logic                  rise, fall;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [I2S_WORD_W-1:0] shift_q, shift_nxt;
  logic [WARM_W-1:0]     warm_cnt;
  logic                  wrap_c, cap_slot_c, capture_c, warm_done_c;
  logic                  unused_bits_c;

  i2s_clkgen #(
    .CLKDIV(CLKDIV)
  ) u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .bclk    (i2s_bclk),
    .rise    (rise),
    .fall    (fall)
  );

  assign bit_cnt_nxt = fall ? bit_cnt + BIT_CNT_W'(1) : bit_cnt;
  assign wrap_c      = fall && (bit_cnt == BIT_CNT_W'(LAST_SLOT));
  assign cap_slot_c  = (bit_cnt == BIT_CNT_W'(CAP_SLOT));
  assign warm_done_c = (warm_cnt == WARM_W'(WARM_LAST));
  assign shift_nxt   = {shift_q[I2S_WORD_W-2:0], i2s_sd};
  assign capture_c   = en && rise && (state == ST_SHIFT) && cap_slot_c;

  // The word's low byte is truncated away and the MSB only ever shifts out.
  assign unused_bits_c = ^{shift_q[I2S_WORD_W-1], shift_nxt[I2S_WORD_W-PCM_W-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WARMUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_WARMUP;
    end else begin
      case (state)
        ST_WARMUP: if (wrap_c && warm_done_c) state_nxt = ST_DELAY;
        ST_DELAY:  if (fall) state_nxt = ST_SHIFT;
        ST_SHIFT:  if (fall && cap_slot_c) state_nxt = ST_HOLD;
        ST_HOLD:   if (wrap_c) state_nxt = ST_DELAY;
        default:   state_nxt = ST_WARMUP;
      endcase
    end
  end

  // Frame position, word select and shifter; disabling discards the partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      shift_q   <= '0;
      warm_cnt  <= '0;
    end else if (!en) begin
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      shift_q   <= '0;
      warm_cnt  <= '0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      i2s_lrclk <= bit_cnt_nxt[BIT_CNT_W-1];
      if (rise && (state == ST_SHIFT)) begin
        shift_q <= shift_nxt;
      end
      if (wrap_c && (state == ST_WARMUP) && !warm_done_c) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end
    end
  end

  // Consumer hand-off: a capture wins over an ack in the same clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcm_out     <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (en) begin
      if (capture_c) begin
        pcm_out     <= shift_nxt[I2S_WORD_W-1 -: PCM_W];
        audio_valid <= 1'b1;
        if (audio_valid && !sample_ack) begin
          overrun <= 1'b1;
        end
      end else if (sample_ack) begin
        audio_valid <= 1'b0;
      end
    end
  end

endmodule
